prog_switch_box_dbuf: RTL and testbench
=======================================

Name: prog_switch_box_dbuf

Overview:
- Parametrised, double-buffered successor to the fabric switch box; connects WIDTH routing tracks on four sides (left/top/right/bottom) through one 4:1 programmable selector per output track.
- Configuration arrives over a serial scan chain into a shadow register, is qualified by a bit counter, and takes effect only on an explicit commit.
- Live routing is never disturbed by shifting.
- Selectable track topology (disjoint, or rotated turns) so routing channels can be built without per-tile wiring edits.

Parameters:
- WIDTH, 2, tracks per side (>=1).
- TOPOLOGY, 0, 0 = disjoint (track i connects only to track i); 1 = rotated turns (straight L<->R and T<->B use track i; turning connections use track (i+1) mod WIDTH).
- CFG_BITS (localparam), 8*WIDTH, config bits = 4 muxes/track x 2 select bits.
- CNT_W (localparam), clog2(CFG_BITS+2), bit-counter width.

Ports:
- config_clk, input, 1, sole clock, rising edge.
- sys_reset, input, 1, synchronous, active-high reset.
- config_in, input, 1, serial config data.
- config_en, input, 1, shift enable.
- config_commit, input, 1, copy shadow to active.
- config_out, output, 1, serial chain output (shadow MSB).
- cfg_ready, output, 1, exactly CFG_BITS bits shifted since last reset/commit.
- cfg_valid, output, 1, at least one successful commit since reset.
- cfg_err, output, 1, sticky commit-protocol error.
- l_in, t_in, r_in, b_in, input, WIDTH each, side track inputs.
- l_out, t_out, r_out, b_out, output, WIDTH each, side track outputs.

Behaviour:
- Clock and reset: one clock (config_clk). Reset (sys_reset) is synchronous, active-high. While sys_reset is high, all other inputs are ignored.
- Reset values: shadow = 0, active = 0, counter = 0, cfg_valid = 0, cfg_err = 0, config_out = 0. All track outputs = 0, because select 0 drives constant 0.
- Shift: when config_en = 1, shadow <= {shadow[CFG_BITS-2:0], config_in} and config_out = shadow[CFG_BITS-1] (registered, one bit per cycle).
  - Counter increments and saturates at CFG_BITS+1 (overshift).
  - Chain passthrough latency from config_in to config_out is CFG_BITS cycles, so tiles can be daisy-chained.
- Select mapping: mux k = 4*i + s, with i = track and s = 0 L, 1 T, 2 R, 3 B. Its select is active[2k+1:2k].
  - The first bit shifted lands in the MSB, i.e. bit 1 of mux 4*WIDTH-1.
- Mux inputs (select 0 drives constant 0 in every case):
  - l_out: 1 = t_in, 2 = r_in, 3 = b_in.
  - t_out: 1 = l_in, 2 = r_in, 3 = b_in.
  - r_out: 1 = l_in, 2 = t_in, 3 = b_in.
  - b_out: 1 = l_in, 2 = t_in, 3 = r_in.
  - Track index is i, or (i+1) mod WIDTH for turning pairs when TOPOLOGY = 1.
- Datapath: track outputs are purely combinational from inputs and the active register. Zero data latency.
- Commit rules:
  - Accepted commit: config_commit = 1, config_en = 0, and counter == CFG_BITS. On the next edge: active <= shadow, counter <= 0, cfg_valid <= 1. New routing is visible the cycle after the edge.
  - Rejected commit: counter != CFG_BITS (under- or overshift). Active is unchanged, cfg_err <= 1, counter unchanged.
  - Simultaneous config_en and config_commit: the shift is performed, the commit is rejected, cfg_err <= 1.
- cfg_ready = (counter == CFG_BITS), combinational from the counter.
- cfg_err is sticky; it clears only on sys_reset.
- Reset mid-shift or mid-commit: everything returns to reset values on that edge. The partially shifted shadow is discarded.
- WIDTH = 1 with TOPOLOGY = 1: (i+1) mod 1 = 0, so it behaves identically to disjoint.

Test Plan:
- Reset check: WIDTH=2, hold sys_reset 2 cycles, drive all inputs = 2'b11 -> every output = 0, config_out = 0, cfg_valid = 0, cfg_err = 0.
- Full load: shift 16 bits programming every mux to select 2, then commit -> cfg_ready = 1 before commit. After commit: l_out = r_in, t_out = r_in, r_out = t_in, b_out = t_in. Counter = 0, cfg_valid = 1.
- Double buffering: with routing active, shift a new pattern without commit -> outputs unchanged for all 16 shift cycles. Then commit -> new routing visible the next cycle.
- Protocol errors: commit after 15 shifts -> cfg_err = 1, outputs unchanged. Reset, shift 17 bits, commit -> rejected, cfg_err = 1. Reset, raise config_en and config_commit together at count 15 -> shift happens, commit rejected.
- Chaining: two instances chained, 32 bits shifted, both commit together -> both tiles route as programmed. First instance's config_out equals its config_in delayed 16 cycles.
- Topology: TOPOLOGY=1, WIDTH=4, program l_out[0] select 1 and r_out[0] select 1 -> l_out[0] follows t_in[1] (turn), r_out[0] follows l_in[0] (straight). l_out[3] select 1 -> follows t_in[0] (wrap-around).

Source files
------------

// File: rtl/prog_switch_box_dbuf.sv
// Double-buffered programmable switch box: a serial scan chain loads a shadow register,
// and a qualified commit copies it into the active register that drives the 4:1 track selectors.
module prog_switch_box_dbuf #(
   parameter int WIDTH    = 2,
   parameter int TOPOLOGY = 0
) (
   input  logic             config_clk,
   input  logic             sys_reset,
   input  logic             config_in,
   input  logic             config_en,
   input  logic             config_commit,
   output logic             config_out,
   output logic             cfg_ready,
   output logic             cfg_valid,
   output logic             cfg_err,
   input  logic [WIDTH-1:0] l_in,
   input  logic [WIDTH-1:0] t_in,
   input  logic [WIDTH-1:0] r_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] l_out,
   output logic [WIDTH-1:0] t_out,
   output logic [WIDTH-1:0] r_out,
   output logic [WIDTH-1:0] b_out
);

   localparam int CFG_BITS = 8 * WIDTH;
   localparam int CNT_W    = $clog2(CFG_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_BITS + 1);

   logic [CFG_BITS-1:0] shadow;
   logic [CFG_BITS-1:0] active;
   logic [CNT_W-1:0]    cnt;
   logic                commit_ok;

   // A commit is honoured only on an idle chain holding exactly one full frame.
   assign commit_ok  = config_commit && !config_en && (cnt == CNT_FULL);
   assign cfg_ready  = (cnt == CNT_FULL);
   assign config_out = shadow[CFG_BITS-1];

   always_ff @(posedge config_clk) begin
      if (sys_reset) begin
         shadow    <= '0;
         active    <= '0;
         cnt       <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         if (config_en) begin
            shadow <= {shadow[CFG_BITS-2:0], config_in};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
         end
         if (commit_ok) begin
            active    <= shadow;
            cnt       <= '0;
            cfg_valid <= 1'b1;
         end else if (config_commit) begin
            cfg_err <= 1'b1;
         end
      end
   end

   // Select 0 always parks the output at constant 0.
   function automatic logic pick(input logic [1:0] sel, input logic a, input logic b,
                                 input logic c);
      case (sel)
         2'd1:    pick = a;
         2'd2:    pick = b;
         2'd3:    pick = c;
         default: pick = 1'b0;
      endcase
   endfunction

   for (genvar i = 0; i < WIDTH; i++) begin : g_track
      // Turning connections use the rotated track when TOPOLOGY selects rotated turns.
      localparam int J = (TOPOLOGY == 1) ? ((i + 1) % WIDTH) : i;
      assign l_out[i] = pick(active[8*i+0 +: 2], t_in[J], r_in[i], b_in[J]);
      assign t_out[i] = pick(active[8*i+2 +: 2], l_in[J], r_in[J], b_in[i]);
      assign r_out[i] = pick(active[8*i+4 +: 2], l_in[i], t_in[J], b_in[J]);
      assign b_out[i] = pick(active[8*i+6 +: 2], l_in[J], t_in[i], r_in[J]);
   end

endmodule

// File: tb/tb_prog_switch_box_dbuf.sv
// Directed bench for prog_switch_box_dbuf: routing tables, double buffering, commit
// protocol errors, daisy chaining and rotated-turn topology.
module tb_prog_switch_box_dbuf;

   typedef struct {
      logic [1:0] l, t, r, b;
      logic [1:0] el, et, er, eb;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic cin_a, en_a, en_b, cm;
   logic cout_a, rdy_a, val_a, err_a;
   logic cout_b, rdy_b, val_b, err_b;
   logic [1:0] l_in, t_in, r_in, b_in;
   logic [1:0] la, ta, ra, ba, lb, tb2, rb, bb;
   logic cin_c, en_c, cm_c, cout_c, rdy_c, val_c, err_c;
   logic [3:0] lc_in, tc_in, rc_in, bc_in, lc, tc, rc, bc;

   vec_t vec[9];
   int n_vec = 0;
   int n_err = 0;
   logic [15:0] cfg1 = 16'hAAAA;
   logic [15:0] cfg2 = 16'h27DD;

   always #5 clk = ~clk;

   prog_switch_box_dbuf #(.WIDTH(2), .TOPOLOGY(0)) dut_a (
      .config_clk(clk), .sys_reset(rst), .config_in(cin_a), .config_en(en_a),
      .config_commit(cm), .config_out(cout_a), .cfg_ready(rdy_a), .cfg_valid(val_a),
      .cfg_err(err_a), .l_in(l_in), .t_in(t_in), .r_in(r_in), .b_in(b_in),
      .l_out(la), .t_out(ta), .r_out(ra), .b_out(ba));

   prog_switch_box_dbuf #(.WIDTH(2), .TOPOLOGY(0)) dut_b (
      .config_clk(clk), .sys_reset(rst), .config_in(cout_a), .config_en(en_b),
      .config_commit(cm), .config_out(cout_b), .cfg_ready(rdy_b), .cfg_valid(val_b),
      .cfg_err(err_b), .l_in(l_in), .t_in(t_in), .r_in(r_in), .b_in(b_in),
      .l_out(lb), .t_out(tb2), .r_out(rb), .b_out(bb));

   prog_switch_box_dbuf #(.WIDTH(4), .TOPOLOGY(1)) dut_c (
      .config_clk(clk), .sys_reset(rst), .config_in(cin_c), .config_en(en_c),
      .config_commit(cm_c), .config_out(cout_c), .cfg_ready(rdy_c), .cfg_valid(val_c),
      .cfg_err(err_c), .l_in(lc_in), .t_in(tc_in), .r_in(rc_in), .b_in(bc_in),
      .l_out(lc), .t_out(tc), .r_out(rc), .b_out(bc));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic shift_bits(input logic [31:0] v, input int nb, input logic with_b);
      for (int n = nb - 1; n >= 0; n--) begin
         cin_a = v[n];
         en_a  = 1'b1;
         en_b  = with_b;
         tick();
      end
      en_a = 1'b0;
      en_b = 1'b0;
   endtask

   task automatic commit();
      cm = 1'b1;
      tick();
      cm = 1'b0;
   endtask

   task automatic apply_row(input int idx);
      l_in = vec[idx].l;
      t_in = vec[idx].t;
      r_in = vec[idx].r;
      b_in = vec[idx].b;
      #1;
   endtask

   task automatic check_row(input int idx, input logic on_b, input string name);
      if (!on_b) begin
         chk({name, ".l_out"}, 32'(la), 32'(vec[idx].el));
         chk({name, ".t_out"}, 32'(ta), 32'(vec[idx].et));
         chk({name, ".r_out"}, 32'(ra), 32'(vec[idx].er));
         chk({name, ".b_out"}, 32'(ba), 32'(vec[idx].eb));
      end else begin
         chk({name, ".b.l_out"}, 32'(lb), 32'(vec[idx].el));
         chk({name, ".b.t_out"}, 32'(tb2), 32'(vec[idx].et));
         chk({name, ".b.r_out"}, 32'(rb), 32'(vec[idx].er));
         chk({name, ".b.b_out"}, 32'(bb), 32'(vec[idx].eb));
      end
   endtask

   initial begin
      // rows 0-3: every mux on select 2; rows 4-7: mixed pattern 16'h27DD; row 8: reset
      vec[0] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b10, 2'b10};
      vec[1] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01};
      vec[2] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
      vec[3] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
      vec[4] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
      vec[5] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
      vec[6] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
      vec[7] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
      vec[8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};

      // Reset with every input held high; all of it must be ignored.
      cin_a = 1'b1; en_a = 1'b1; en_b = 1'b1; cm = 1'b1;
      cin_c = 1'b1; en_c = 1'b1; cm_c = 1'b1;
      lc_in = '1; tc_in = '1; rc_in = '1; bc_in = '1;
      apply_row(8);
      do_reset();
      en_a = 1'b0; en_b = 1'b0; cm = 1'b0; en_c = 1'b0; cm_c = 1'b0;
      #1;
      check_row(8, 1'b0, "reset");
      chk("reset.config_out", 32'(cout_a), 0);
      chk("reset.cfg_valid", 32'(val_a), 0);
      chk("reset.cfg_err", 32'(err_a), 0);
      chk("reset.cfg_ready", 32'(rdy_a), 0);

      // Full load, all selects = 2.
      shift_bits(32'(cfg1), 16, 1'b0);
      chk("load.ready_before", 32'(rdy_a), 1);
      chk("load.valid_before", 32'(val_a), 0);
      commit();
      chk("load.valid_after", 32'(val_a), 1);
      chk("load.ready_after", 32'(rdy_a), 0);
      for (int i = 0; i < 4; i++) begin
         apply_row(i);
         check_row(i, 1'b0, $sformatf("cfg1[%0d]", i));
      end

      // Double buffering: routing holds while a new frame shifts in.
      apply_row(0);
      for (int n = 15; n >= 0; n--) begin
         cin_a = cfg2[n];
         en_a  = 1'b1;
         tick();
         check_row(0, 1'b0, $sformatf("dbuf_hold[%0d]", n));
      end
      en_a = 1'b0;
      commit();
      for (int i = 4; i < 8; i++) begin
         apply_row(i);
         check_row(i, 1'b0, $sformatf("cfg2[%0d]", i));
      end
      chk("dbuf.err", 32'(err_a), 0);

      // Undershift commit: rejected, routing and counter untouched.
      shift_bits(32'h0, 15, 1'b0);
      commit();
      chk("under.err", 32'(err_a), 1);
      chk("under.valid", 32'(val_a), 1);
      apply_row(5);
      check_row(5, 1'b0, "under.route");
      shift_bits(32'h0, 1, 1'b0);
      chk("under.count_kept", 32'(rdy_a), 1);

      // Overshift commit.
      do_reset();
      chk("over.err_cleared", 32'(err_a), 0);
      shift_bits(32'h1FFFF, 17, 1'b0);
      chk("over.ready", 32'(rdy_a), 0);
      commit();
      chk("over.err", 32'(err_a), 1);
      chk("over.valid", 32'(val_a), 0);
      apply_row(8);
      check_row(8, 1'b0, "over.route");

      // Shift and commit together at count 15: shift lands, commit rejected.
      do_reset();
      shift_bits(32'h4000, 15, 1'b0);
      cin_a = 1'b0; en_a = 1'b1; cm = 1'b1;
      tick();
      en_a = 1'b0; cm = 1'b0;
      chk("simul.err", 32'(err_a), 1);
      chk("simul.valid", 32'(val_a), 0);
      chk("simul.ready", 32'(rdy_a), 1);
      chk("simul.config_out", 32'(cout_a), 1);

      // Chain: tile b's frame passes through tile a, then both commit together.
      do_reset();
      shift_bits(32'(cfg1), 16, 1'b0);
      commit();
      for (int n = 15; n >= 0; n--) begin
         chk($sformatf("chain.config_out[%0d]", n), 32'(cout_a), 32'(cfg1[n]));
         cin_a = cfg2[n];
         en_a  = 1'b1;
         en_b  = 1'b1;
         tick();
      end
      en_a = 1'b0; en_b = 1'b0;
      chk("chain.ready_a", 32'(rdy_a), 1);
      chk("chain.ready_b", 32'(rdy_b), 1);
      commit();
      chk("chain.valid_b", 32'(val_b), 1);
      for (int i = 0; i < 4; i++) begin
         apply_row(i + 4);
         check_row(i + 4, 1'b0, $sformatf("chain.a[%0d]", i));
         check_row(i, 1'b1, $sformatf("chain.b[%0d]", i));
      end

      // Rotated turns, WIDTH=4: l_out[0]<-t_in[1], r_out[0]<-l_in[0], l_out[3]<-t_in[0].
      do_reset();
      for (int n = 31; n >= 0; n--) begin
         logic [31:0] w;
         w     = 32'h0100_0011;
         cin_c = w[n];
         en_c  = 1'b1;
         tick();
      end
      en_c = 1'b0;
      chk("topo.ready", 32'(rdy_c), 1);
      cm_c = 1'b1;
      tick();
      cm_c = 1'b0;
      chk("topo.valid", 32'(val_c), 1);
      rc_in = 4'b0000; bc_in = 4'b1111;
      tc_in = 4'b0010; lc_in = 4'b0001; #1;
      chk("topo1.l_out", 32'(lc), 32'h1);
      chk("topo1.r_out", 32'(rc), 32'h1);
      chk("topo1.t_out", 32'(tc), 32'h0);
      chk("topo1.b_out", 32'(bc), 32'h0);
      tc_in = 4'b0001; lc_in = 4'b1110; #1;
      chk("topo2.l_out", 32'(lc), 32'h8);
      chk("topo2.r_out", 32'(rc), 32'h0);
      tc_in = 4'b1101; lc_in = 4'b0000; #1;
      chk("topo3.l_out", 32'(lc), 32'h8);
      chk("topo3.r_out", 32'(rc), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
